// File: rtl/rpsc_seq_pkg.sv
// Shared types and default timing for the RPSC card-3 power sequencer.
// Default constants assume the 1.28 us card clock.
package rpsc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DRV_UP  = 3'd1,
      ST_G2_UP   = 3'd2,
      ST_AN_UP   = 3'd3,
      ST_RUN     = 3'd4,
      ST_RAMP_DN = 3'd5,
      ST_FAULT   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      FC_NONE     = 3'd0,
      FC_ALARM    = 3'd1,
      FC_DRV_TO   = 3'd2,
      FC_G2_TO    = 3'd3,
      FC_GND      = 3'd4,
      FC_DRV_LOST = 3'd5,
      FC_G2_LOST  = 3'd6
   } fault_t;

   localparam int DEF_CNT_W     = 23;
   localparam int DEF_TIMEOUT   = 3906250;  // 5 s
   localparam int DEF_AN_SETTLE = 390625;   // 0.5 s
   localparam int DEF_OFF_DELAY = 78125;    // 0.1 s
   localparam int DEF_MAX_RETRY = 2;

endpackage

// File: rtl/rpsc_seq_counter.sv
// Step counter: saturating at all-ones, synchronous clear, async active-low reset.
module rpsc_seq_counter #(
   parameter int CNT_W = 23
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              r_cnt <= '0;
      else if (i_clr)          r_cnt <= '0;
      else if (r_cnt != '1)    r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/rpsc_power_sequencer.sv
// RPSC card-3 supply sequencer: drv amp -> G2 -> anode up, reverse down, fault latch.
// Optional timeout auto-retry enabled by defining RPSC_SEQ_AUTORETRY_EN.
module rpsc_power_sequencer
   import rpsc_seq_pkg::*;
#(
   parameter int               CNT_W     = DEF_CNT_W,
   parameter logic [CNT_W-1:0] TIMEOUT   = CNT_W'(DEF_TIMEOUT),
   parameter logic [CNT_W-1:0] AN_SETTLE = CNT_W'(DEF_AN_SETTLE),
   parameter logic [CNT_W-1:0] OFF_DELAY = CNT_W'(DEF_OFF_DELAY),
   parameter int               MAX_RETRY = DEF_MAX_RETRY
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_req,
   input  logic       stop_req,
   input  logic       fault_ack,
   input  logic       not_alarm,
   input  logic       ground_hold_ok,
   input  logic       g2_ok,
   input  logic       dr_amp_ok,
   output logic       dr_amp_en,
   output logic       g2_ps_en,
   output logic       an_ps_en,
   output logic       running,
   output logic       fault_latched,
   output logic [2:0] fault_code,
   output logic [2:0] state_o,
   output logic [1:0] retry_count
);

`ifdef RPSC_SEQ_AUTORETRY_EN
   localparam bit AUTORETRY = 1'b1;
`else
   localparam bit AUTORETRY = 1'b0;
`endif

   localparam logic [CNT_W-1:0] TO_M1     = TIMEOUT - 1'b1;
   localparam logic [CNT_W-1:0] AS_M1     = AN_SETTLE - 1'b1;
   localparam logic [CNT_W-1:0] OD_M1     = OFF_DELAY - 1'b1;
   localparam logic [CNT_W-1:0] OD2_M1    = (OFF_DELAY << 1) - 1'b1;
   localparam logic [1:0]       RETRY_LIM = 2'(MAX_RETRY);

   state_t           r_st;
   fault_t           r_code;
   logic             r_dr, r_g2, r_an, r_run, r_flt, r_restart;
   logic [1:0]       r_retry;
   logic [CNT_W-1:0] w_cnt;
   state_t           w_nxt;
   fault_t           w_fault, w_to_code, w_code;
   logic             w_an_st, w_active, w_retry_go, w_clr;

   rpsc_seq_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .i_clr (w_clr),
      .o_cnt (w_cnt)
   );

   always_comb begin
      w_an_st    = (r_st == ST_AN_UP) || (r_st == ST_RUN);
      w_active   = (r_st == ST_DRV_UP) || (r_st == ST_G2_UP) || w_an_st;
      w_fault    = FC_NONE;
      w_to_code  = FC_NONE;
      w_retry_go = 1'b0;
      w_nxt      = r_st;
      if (r_st != ST_IDLE && r_st != ST_FAULT) begin
         if (!not_alarm)                                       w_fault = FC_ALARM;
         else if (!ground_hold_ok && w_an_st)                  w_fault = FC_GND;
         else if (!dr_amp_ok && (r_st == ST_G2_UP || w_an_st)) w_fault = FC_DRV_LOST;
         else if (!g2_ok && w_an_st)                           w_fault = FC_G2_LOST;
      end
      if (r_st == ST_DRV_UP && !dr_amp_ok && w_cnt == TO_M1)  w_to_code = FC_DRV_TO;
      else if (r_st == ST_G2_UP && !g2_ok && w_cnt == TO_M1)  w_to_code = FC_G2_TO;
      w_code = (w_fault != FC_NONE) ? w_fault : w_to_code;
      case (r_st)
         ST_IDLE:
            if (not_alarm && ground_hold_ok && !stop_req && (start_req || r_restart))
               w_nxt = ST_DRV_UP;
         ST_FAULT:
            if (fault_ack && not_alarm) w_nxt = ST_IDLE;
         default:
            if (w_fault != FC_NONE)            w_nxt = ST_FAULT;
            else if (stop_req && w_active)     w_nxt = ST_RAMP_DN;
            else if (w_to_code != FC_NONE) begin
               if (AUTORETRY && r_retry < RETRY_LIM) begin
                  w_nxt      = ST_RAMP_DN;
                  w_retry_go = 1'b1;
               end else begin
                  w_nxt = ST_FAULT;
               end
            end else begin
               case (r_st)
                  ST_DRV_UP:  if (dr_amp_ok)       w_nxt = ST_G2_UP;
                  ST_G2_UP:   if (g2_ok)           w_nxt = ST_AN_UP;
                  ST_AN_UP:   if (w_cnt == AS_M1)  w_nxt = ST_RUN;
                  ST_RAMP_DN: if (w_cnt == OD2_M1) w_nxt = ST_IDLE;
                  default: ;
               endcase
            end
      endcase
      w_clr = (w_nxt != r_st);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_st      <= ST_IDLE;
         r_code    <= FC_NONE;
         r_dr      <= 1'b0;
         r_g2      <= 1'b0;
         r_an      <= 1'b0;
         r_run     <= 1'b0;
         r_flt     <= 1'b0;
         r_restart <= 1'b0;
         r_retry   <= '0;
      end else begin
         r_st  <= w_nxt;
         r_run <= (w_nxt == ST_RUN);
         case (w_nxt)
            ST_DRV_UP:        {r_dr, r_g2, r_an} <= 3'b100;
            ST_G2_UP:         {r_dr, r_g2, r_an} <= 3'b110;
            ST_AN_UP, ST_RUN: {r_dr, r_g2, r_an} <= 3'b111;
            ST_RAMP_DN: begin
               // anode off on entry, G2 after one OFF_DELAY, drv amp drops with the IDLE exit
               r_an <= 1'b0;
               if (r_st == ST_RAMP_DN && w_cnt == OD_M1) r_g2 <= 1'b0;
            end
            default:          {r_dr, r_g2, r_an} <= 3'b000;
         endcase
         if (r_st != ST_FAULT && w_nxt == ST_FAULT) begin
            r_flt  <= 1'b1;
            r_code <= w_code;
         end else if (r_st == ST_FAULT && w_nxt == ST_IDLE) begin
            r_flt  <= 1'b0;
            r_code <= FC_NONE;
         end
         if (AUTORETRY) begin
            if (w_retry_go)
               r_restart <= 1'b1;
            else if (w_nxt == ST_FAULT || w_nxt == ST_DRV_UP || (w_nxt == ST_RAMP_DN && r_st != ST_RAMP_DN))
               r_restart <= 1'b0;
            if (r_st == ST_IDLE && w_nxt == ST_DRV_UP && r_restart)
               r_retry <= r_retry + 1'b1;
            else if ((r_st == ST_AN_UP && w_nxt == ST_RUN) ||
                     (r_st != ST_RAMP_DN && w_nxt == ST_RAMP_DN && !w_retry_go) ||
                     (r_st == ST_FAULT && w_nxt == ST_IDLE))
               r_retry <= '0;
         end
      end
   end

   assign dr_amp_en     = r_dr;
   assign g2_ps_en      = r_g2;
   assign an_ps_en      = r_an;
   assign running       = r_run;
   assign fault_latched = r_flt;
   assign fault_code    = r_code;
   assign state_o       = r_st;
   assign retry_count   = r_retry;

endmodule

// File: tb/tb_rpsc_power_sequencer.sv
// Bench for rpsc_power_sequencer: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a behavioural model.
module tb_rpsc_power_sequencer;

   localparam int TO = 10, AS = 4, OD = 3, MAXR = 2;
`ifdef RPSC_SEQ_AUTORETRY_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif

   logic clk, reset;
   logic start_req, stop_req, fault_ack, not_alarm, ground_hold_ok, g2_ok, dr_amp_ok;
   logic dr_amp_en, g2_ps_en, an_ps_en, running, fault_latched;
   logic [2:0] fault_code, state_o;
   logic [1:0] retry_count;

   int checks = 0, errors = 0;
   bit cmp_en = 0;

   rpsc_power_sequencer #(.CNT_W(23), .TIMEOUT(TO), .AN_SETTLE(AS), .OFF_DELAY(OD), .MAX_RETRY(MAXR)) dut (
      .clk(clk), .reset(reset), .start_req(start_req), .stop_req(stop_req), .fault_ack(fault_ack),
      .not_alarm(not_alarm), .ground_hold_ok(ground_hold_ok), .g2_ok(g2_ok), .dr_amp_ok(dr_amp_ok),
      .dr_amp_en(dr_amp_en), .g2_ps_en(g2_ps_en), .an_ps_en(an_ps_en), .running(running),
      .fault_latched(fault_latched), .fault_code(fault_code), .state_o(state_o), .retry_count(retry_count)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: state number, cycles spent in state, latched code, retries, restart flag,
   // and whether G2 was on when ramp-down began.
   int m_st = 0, m_tis = 0, m_code = 0, m_retry = 0;
   bit m_rs = 0, m_g2ent = 0;

   always @(posedge clk or negedge reset) begin
      int nst, f, tc;
      if (!reset) begin
         m_st = 0; m_tis = 0; m_code = 0; m_retry = 0; m_rs = 0; m_g2ent = 0;
      end else begin
         f = 0; tc = 0; nst = m_st;
         if (m_st != 0 && m_st != 6) begin
            if (!not_alarm)                                  f = 1;
            else if (!ground_hold_ok && m_st inside {3, 4})  f = 4;
            else if (!dr_amp_ok && m_st inside {2, 3, 4})    f = 5;
            else if (!g2_ok && m_st inside {3, 4})           f = 6;
         end
         if (m_st == 1 && !dr_amp_ok && m_tis == TO - 1) tc = 2;
         if (m_st == 2 && !g2_ok && m_tis == TO - 1)     tc = 3;
         if (m_st == 0) begin
            if (not_alarm && ground_hold_ok && !stop_req && (start_req || m_rs)) begin
               nst = 1;
               if (m_rs) m_retry++;
               m_rs = 0;
            end
         end else if (m_st == 6) begin
            if (fault_ack && not_alarm) begin nst = 0; m_code = 0; m_retry = 0; end
         end else if (f != 0) begin
            nst = 6; m_code = f; m_rs = 0;
         end else if (stop_req && m_st <= 4) begin
            nst = 5; m_g2ent = (m_st >= 2); m_retry = 0; m_rs = 0;
         end else if (tc != 0) begin
            if (AR && m_retry < MAXR) begin nst = 5; m_g2ent = (m_st >= 2); m_rs = 1; end
            else begin nst = 6; m_code = tc; end
         end else if (m_st == 1 && dr_amp_ok)        nst = 2;
         else if (m_st == 2 && g2_ok)                nst = 3;
         else if (m_st == 3 && m_tis == AS - 1) begin nst = 4; m_retry = 0; end
         else if (m_st == 5 && m_tis == 2 * OD - 1)  nst = 0;
         m_tis = (nst != m_st) ? 0 : m_tis + 1;
         m_st  = nst;
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("m_state", state_o, m_st);
         chk("m_dr_en", dr_amp_en, (m_st inside {1, 2, 3, 4, 5}) ? 1 : 0);
         chk("m_g2_en", g2_ps_en, ((m_st inside {2, 3, 4}) || (m_st == 5 && m_g2ent && m_tis < OD)) ? 1 : 0);
         chk("m_an_en", an_ps_en, (m_st inside {3, 4}) ? 1 : 0);
         chk("m_running", running, (m_st == 4) ? 1 : 0);
         chk("m_latched", fault_latched, (m_st == 6) ? 1 : 0);
         chk("m_code", fault_code, m_code);
         chk("m_retry", retry_count, m_retry);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_state(input int s, input int budget, input string nm);
      int n = 0;
      while (state_o !== 3'(s) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(nm, state_o, s);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int mode;
      reset = 0; start_req = 0; stop_req = 0; fault_ack = 0;
      not_alarm = 1; ground_hold_ok = 1; g2_ok = 0; dr_amp_ok = 0;
      cmp_en = 1;
      cyc(2);
      chk("rst_state", state_o, 0);
      chk("rst_en", {dr_amp_en, g2_ps_en, an_ps_en}, 0);
      chk("rst_flags", {running, fault_latched, fault_code, retry_count}, 0);
      reset = 1;

      // nominal power-up
      start_req = 1;
      cyc(1); chk("up_drv", state_o, 1); chk("up_dr_en", dr_amp_en, 1);
      cyc(1); dr_amp_ok = 1;
      cyc(1); chk("up_g2", state_o, 2); chk("up_g2_en", g2_ps_en, 1);
      cyc(2); g2_ok = 1;
      cyc(1); chk("up_an", state_o, 3); chk("up_an_en", an_ps_en, 1);
      cyc(3); chk("up_not_yet_run", running, 0);
      cyc(1); chk("up_run", state_o, 4); chk("up_running", running, 1);
      chk("model_run", m_st, 4);
      start_req = 0;

      // ordered power-down
      stop_req = 1;
      cyc(1); chk("dn_ramp", state_o, 5); chk("dn_en_a", {dr_amp_en, g2_ps_en, an_ps_en}, 3'b110);
      cyc(2); chk("dn_g2_held", g2_ps_en, 1);
      cyc(1); chk("dn_en_b", {dr_amp_en, g2_ps_en, an_ps_en}, 3'b100);
      cyc(2); chk("dn_dr_held", dr_amp_en, 1);
      cyc(1); chk("dn_idle", state_o, 0); chk("dn_dr_off", dr_amp_en, 0); chk("dn_code", fault_code, 0);
      stop_req = 0;

      // driver-amp timeout
      dr_amp_ok = 0; g2_ok = 0; start_req = 1;
      cyc(1); chk("to_drv", state_o, 1);
      start_req = 0;
`ifdef RPSC_SEQ_AUTORETRY_EN
      for (int r = 1; r <= 2; r++) begin
         wait_state(5, 20, "to_retry_ramp");
         wait_state(1, 20, "to_retry_drv");
         chk("to_retry_cnt", retry_count, r);
      end
      wait_state(6, 20, "to_fault");
      chk("to_code", fault_code, 2);
      chk("to_en", {dr_amp_en, g2_ps_en, an_ps_en}, 0);
`else
      cyc(9); chk("to_still_drv", state_o, 1);
      cyc(1); chk("to_fault", state_o, 6); chk("to_code", fault_code, 2);
      chk("to_en", {dr_amp_en, g2_ps_en, an_ps_en}, 0); chk("to_latched", fault_latched, 1);
      chk("model_to_code", m_code, 2);
`endif

      // acknowledge needs not_alarm; held start waits for IDLE
      not_alarm = 0; fault_ack = 1; start_req = 1;
      cyc(2); chk("ack_hold", state_o, 6); chk("ack_hold_code", fault_code, 2);
      not_alarm = 1;
      cyc(1); chk("ack_idle", state_o, 0); chk("ack_latched", fault_latched, 0); chk("ack_code", fault_code, 0);
      cyc(1); chk("ack_restart", state_o, 1);
      fault_ack = 0; start_req = 0; dr_amp_ok = 1; g2_ok = 1;
      wait_state(4, 20, "pri_run");

      // simultaneous alarm, ground drop and stop: alarm wins
      not_alarm = 0; ground_hold_ok = 0; stop_req = 1;
      cyc(1); chk("pri_fault", state_o, 6); chk("pri_code", fault_code, 1);
      chk("pri_en", {dr_amp_en, g2_ps_en, an_ps_en}, 0);
      not_alarm = 1; ground_hold_ok = 1; stop_req = 0; g2_ok = 0;
      cyc(2); chk("pri_code_kept", fault_code, 1);
      fault_ack = 1;
      cyc(1); chk("pri_ack", state_o, 0);
      fault_ack = 0; g2_ok = 1;

      // asynchronous reset in AN_UP
      start_req = 1;
      wait_state(3, 20, "rst_an_up");
      start_req = 0;
      @(posedge clk); #2 reset = 0;
      #1 chk("arst_en", {dr_amp_en, g2_ps_en, an_ps_en}, 0); chk("arst_state", state_o, 0);
      cyc(2); reset = 1;
      chk("arst_idle", state_o, 0);
      start_req = 1;
      cyc(1); chk("arst_restart", state_o, 1);
      start_req = 0;

      // randomized traffic
      mode = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) mode = $urandom_range(0, 3);
         start_req      = ($urandom_range(0, 3) == 0);
         stop_req       = ($urandom_range(0, 39) == 0);
         fault_ack      = ($urandom_range(0, 7) == 0);
         not_alarm      = ($urandom_range(0, 59) != 0);
         ground_hold_ok = ($urandom_range(0, 59) != 0);
         case (mode)
            0: begin
               dr_amp_ok = dr_amp_en && ($urandom_range(0, 79) != 0);
               g2_ok     = g2_ps_en && ($urandom_range(0, 79) != 0);
            end
            1: begin dr_amp_ok = 0; g2_ok = g2_ps_en; end
            2: begin dr_amp_ok = dr_amp_en; g2_ok = 0; end
            default: begin dr_amp_ok = $urandom_range(0, 1); g2_ok = $urandom_range(0, 1); end
         endcase
         @(negedge clk);
      end

      cmp_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
